// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder: sliced carry-lookahead adder/subtractor, one slice per stage, valid/ready handshake
module pipelined_cla_adder #(
  parameter int WIDTH = 32,
  parameter int PIPE  = 2,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int SW = WIDTH / PIPE;
  localparam int NG = SW / GROUP;
  logic [WIDTH-1:0] a_q [PIPE];
  logic [WIDTH-1:0] b_q [PIPE];
  logic [WIDTH-1:0] s_q [PIPE];
  logic [PIPE-1:0]  v_q, c_q;
  logic             ovf_q, zero_q;
  logic [WIDTH-1:0] a_d [PIPE];
  logic [WIDTH-1:0] b_d [PIPE];
  logic [WIDTH-1:0] s_d [PIPE];
  logic [SW+1:0]    r_w [PIPE];
  logic [PIPE-1:0]  v_d, ci_w;
  logic             en;

  // returns {carry into slice MSB, carry out, sum}; bit carries are lookahead within each group,
  // groups chain through their group generate/propagate
  function automatic logic [SW+1:0] slice_add(input logic [SW-1:0] x, input logic [SW-1:0] y,
                                              input logic ci);
    logic [SW-1:0] p, g;
    logic [SW:0]   c;
    logic          gg, gp;
    p = x ^ y;
    g = x & y;
    c = '0;
    c[0] = ci;
    for (int j = 0; j < NG; j++) begin
      gg = 1'b0;
      gp = 1'b1;
      for (int i = 0; i < GROUP; i++) begin
        gg = g[j*GROUP+i] | (p[j*GROUP+i] & gg);
        gp = gp & p[j*GROUP+i];
        c[j*GROUP+i+1] = gg | (gp & c[j*GROUP]);
      end
    end
    return {c[SW-1], c[SW], p ^ c[SW-1:0]};
  endfunction

  assign en        = !v_q[PIPE-1] || out_ready;
  assign in_ready  = en;
  assign out_valid = v_q[PIPE-1];
  assign sum       = s_q[PIPE-1];
  assign cout      = c_q[PIPE-1];
  assign ovf       = ovf_q;
  assign zero      = zero_q;

  // each stage adds its own slice using the carry handed over by the previous stage
  always_comb begin
    for (int k = 0; k < PIPE; k++) begin
      a_d[k]  = k == 0 ? a : a_q[k == 0 ? 0 : k-1];
      b_d[k]  = k == 0 ? (sub ? ~b : b) : b_q[k == 0 ? 0 : k-1];
      ci_w[k] = k == 0 ? (sub | cin) : c_q[k == 0 ? 0 : k-1];
      v_d[k]  = k == 0 ? in_valid : v_q[k == 0 ? 0 : k-1];
      s_d[k]  = k == 0 ? '0 : s_q[k == 0 ? 0 : k-1];
      r_w[k]  = slice_add(a_d[k][k*SW +: SW], b_d[k][k*SW +: SW], ci_w[k]);
      s_d[k][k*SW +: SW] = r_w[k][SW-1:0];
    end
  end

  // whole pipe advances together only when the output slot is free or being consumed
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q    <= '0;
      c_q    <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      for (int k = 0; k < PIPE; k++) s_q[k] <= '0;
    end else if (en) begin
      v_q    <= v_d;
      ovf_q  <= r_w[PIPE-1][SW+1] ^ r_w[PIPE-1][SW];
      zero_q <= ~|s_d[PIPE-1];
      for (int k = 0; k < PIPE; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
        c_q[k] <= r_w[k][SW];
      end
    end
  end
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// tb_pipelined_cla_adder: scoreboard bench for the pipelined adder/subtractor
module tb_pipelined_cla_adder #(
  parameter int PIPE  = 2,
  parameter int GROUP = 4
);
  localparam int W = 32;
  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout, ovf, zero;
  } res_t;
  typedef struct packed {
    logic [W-1:0] a, b;
    logic         cin, sub;
    res_t         r;
  } vec_t;

  logic         clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1, cin = 1'b0, sub = 1'b0;
  logic         in_ready, out_valid, cout, ovf, zero;
  logic [W-1:0] a = '0, b = '0, sum;
  int           total = 0, bad = 0;
  bit           mon_en = 1'b1, done;
  res_t         q[$];
  vec_t         tab[14];

  pipelined_cla_adder #(.WIDTH(W), .PIPE(PIPE), .GROUP(GROUP)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .cin(cin),
    .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf),
    .zero(zero)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // hand-computed vectors: a, b, cin, sub -> sum, cout, ovf, zero
  initial begin
    tab[0]  = {32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0};
    tab[1]  = {32'h00000005, 32'h00000005, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
    tab[2]  = {32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
    tab[3]  = {32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
    tab[4]  = {32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
    tab[5]  = {32'h00000003, 32'h00000005, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
    tab[6]  = {32'h12345678, 32'h11111111, 1'b1, 1'b0, 32'h2345678A, 1'b0, 1'b0, 1'b0};
    tab[7]  = {32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0};
    tab[8]  = {32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1};
    tab[9]  = {32'h00000000, 32'h00000000, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
    tab[10] = {32'h0000000A, 32'h00000003, 1'b1, 1'b1, 32'h00000007, 1'b1, 1'b0, 1'b0};
    tab[11] = {32'h00FF00FF, 32'h0F0F0F0F, 1'b0, 1'b0, 32'h100E100E, 1'b0, 1'b0, 1'b0};
    tab[12] = {32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h80000000, 1'b0, 1'b1, 1'b0};
    tab[13] = {32'h0000FFFF, 32'h00010000, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
  end

  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                                 input logic s);
    logic [W-1:0] ye;
    logic [W:0]   t;
    res_t         r;
    ye = s ? ~y : y;
    t = {1'b0, x} + {1'b0, ye} + (W+1)'(s | c);
    r.sum  = t[W-1:0];
    r.cout = t[W];
    r.ovf  = (x[W-1] == ye[W-1]) && (t[W-1] != x[W-1]);
    r.zero = t[W-1:0] == '0;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input vec_t v, input bit push);
    int n;
    @(negedge clk);
    a = v.a;
    b = v.b;
    cin = v.cin;
    sub = v.sub;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL send_wait: in_ready stuck at %0b required 1", in_ready);
    end
    if (push) q.push_back(v.r);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    cin = 1'($urandom);
    sub = 1'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", 64'(q.size()), 64'd0);
  endtask

  // scoreboard: any presented result must equal the queue head; pop only on output transfer
  always @(negedge clk) begin
    if (mon_en && out_valid) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_out: got sum=%h with no result outstanding", sum);
      end else begin
        if ({sum, cout, ovf, zero} !== q[0]) begin
          bad++;
          $display("FAIL result: got sum=%h c=%b v=%b z=%b expected sum=%h c=%b v=%b z=%b",
                   sum, cout, ovf, zero, q[0].sum, q[0].cout, q[0].ovf, q[0].zero);
        end
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  initial begin
    vec_t v;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_sum", 64'(sum), 0);
    chk("rst_flags", 64'({cout, ovf, zero}), 0);
    chk("rst_in_ready", 64'(in_ready), 1);

    send(tab[0], 1'b1);
    for (int i = 0; i < PIPE; i++) begin
      @(negedge clk);
      chk("latency", 64'(out_valid), 64'(i == PIPE - 1));
    end
    for (int i = 1; i < 14; i++) send(tab[i], 1'b1);
    drain();

    fork
      for (int i = 6; i < 12; i++) send(tab[i], 1'b1);
      begin
        repeat (PIPE + 3) @(posedge clk);
        #2 out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("stall_in_ready", 64'(in_ready), 0);
          chk("stall_out_valid", 64'(out_valid), 1);
        end
        @(posedge clk);
        #2 out_ready = 1'b1;
      end
    join
    drain();

    mon_en = 1'b0;
    send(tab[6], 1'b0);
    send(tab[7], 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;
    chk("midrst_out_valid", 64'(out_valid), 0);
    chk("midrst_sum", 64'(sum), 0);
    chk("midrst_flags", 64'({cout, ovf, zero}), 0);
    chk("midrst_in_ready", 64'(in_ready), 1);
    repeat (6) begin
      @(negedge clk);
      chk("midrst_no_stale", 64'(out_valid), 0);
    end

    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          repeat ($urandom_range(0, 2)) @(negedge clk);
          v.a = $urandom;
          v.b = $urandom;
          if (i % 8 == 0) v.b = ~v.a;
          if (i % 8 == 1) v.b = v.a;
          v.cin = 1'($urandom);
          v.sub = 1'($urandom);
          v.r = model(v.a, v.b, v.cin, v.sub);
          send(v, 1'b1);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #2 out_ready = $urandom_range(0, 3) != 0;
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
